decode_issue_ctrl: RTL and testbench

- Front-end sequencer that sits between fetch and the dual-slot decoder (slot A / slot B).
- Buffers fetched instruction pairs in a small FIFO and presents them to the decoder as registered slot A/B instruction, PC and valid signals.
- Splits a pair across two cycles when instB reads a register that instA writes, because slot B reads the register file before slot A's mapping is visible.
- Applies backpressure to fetch and supports pipeline flush.

---
 rtl/decode_issue_ctrl_pkg.sv | 38 +++
 rtl/decode_issue_ctrl_fifo.sv | 59 +++++
 rtl/decode_issue_ctrl.sv | 170 +++++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared definitions for the decode issue controller: NOP encoding, opcodes,
// instruction field positions, issue state and the slot A -> slot B RAW check.
package decode_issue_ctrl_pkg;

  localparam logic [31:0] NOP_INST   = 32'h00000013;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef enum logic {PAIR, SPLIT} issue_state_e;

  // True when inst_b reads a register that inst_a writes in the same pair.
  function automatic logic raw_hazard(input logic [31:0] inst_a, input logic [31:0] inst_b);
    logic [6:0] opc_a;
    logic [6:0] opc_b;
    logic [4:0] rd_a;
    logic [4:0] rs1_b;
    logic [4:0] rs2_b;
    logic       a_writes;
    logic       b_uses_rs2;
    opc_a      = inst_a[OPC_LSB +: 7];
    opc_b      = inst_b[OPC_LSB +: 7];
    rd_a       = inst_a[RD_LSB +: 5];
    rs1_b      = inst_b[RS1_LSB +: 5];
    rs2_b      = inst_b[RS2_LSB +: 5];
    a_writes   = (opc_a != OPC_STORE) && (opc_a != OPC_BRANCH);
    b_uses_rs2 = (opc_b == OPC_OP) || (opc_b == OPC_STORE) || (opc_b == OPC_BRANCH);
    return (rd_a != 5'd0) && a_writes &&
           ((rs1_b == rd_a) || (b_uses_rs2 && (rs2_b == rd_a)));
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_fifo.sv
// issue_pair_fifo: show-ahead FIFO of fetched instruction pairs. The head
// entry is visible on pop_data whenever empty is low; flush empties it.
module issue_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem_reg[rd_ptr_reg];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: buffers fetched pairs and issues them to the dual-slot
// decoder, splitting a pair over two beats when slot B reads slot A's rd.
// Optional performance counters are built when ISSUE_PERF_CNT_EN is defined.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_instA,
  input  logic [XLEN-1:0] fetch_instB,
  input  logic [XLEN-1:0] fetch_pcA,
  input  logic [XLEN-1:0] fetch_pcB,
  output logic            fetch_ready,
  input  logic            dec_ready,
  input  logic            flush,
  output logic [XLEN-1:0] dec_instA,
  output logic [XLEN-1:0] dec_instB,
  output logic [XLEN-1:0] dec_pcA,
  output logic [XLEN-1:0] dec_pcB,
  output logic            dec_validA,
  output logic            dec_validB,
  output logic            split_active
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]     split_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int PW = 4*XLEN;
  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INST);

  issue_state_e    state_reg;
  logic [XLEN-1:0] hold_inst_reg;
  logic [XLEN-1:0] hold_pc_reg;

  logic [PW-1:0]   fetch_pair;
  logic [PW-1:0]   fifo_rdata;
  logic [PW-1:0]   head_pair;
  logic            fifo_full;
  logic            fifo_empty;
  logic            out_valid;
  logic            stage_free;
  logic            show_hold;
  logic            take_new;
  logic            push;
  logic            bypass;
  logic            head_avail;
  logic            head_hazard;
  logic [XLEN-1:0] head_inst_a;
  logic [XLEN-1:0] head_inst_b;
  logic [XLEN-1:0] head_pc_a;
  logic [XLEN-1:0] head_pc_b;

  assign fetch_ready = !fifo_full;
  assign out_valid   = dec_validA || dec_validB;
  assign stage_free  = !out_valid || dec_ready;
  // While in SPLIT without split_active the held B is still waiting its turn.
  assign show_hold   = (state_reg == SPLIT) && !split_active;
  assign take_new    = stage_free && !show_hold;
  assign push        = fetch_valid && fetch_ready && !flush;
  // An empty FIFO lets the pushed pair go straight to the output stage.
  assign bypass      = take_new && fifo_empty;
  assign fetch_pair  = {fetch_instA, fetch_instB, fetch_pcA, fetch_pcB};
  assign head_pair   = fifo_empty ? fetch_pair : fifo_rdata;
  assign head_avail  = !fifo_empty || push;
  assign {head_inst_a, head_inst_b, head_pc_a, head_pc_b} = head_pair;
  assign head_hazard = raw_hazard(head_inst_a[31:0], head_inst_b[31:0]);

  issue_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push && !bypass),
    .push_data (fetch_pair),
    .pop       (take_new && !fifo_empty),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue FSM with registered slot outputs and the held second half of a split.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= PAIR;
      hold_inst_reg <= NOP;
      hold_pc_reg   <= '0;
      dec_instA     <= NOP;
      dec_instB     <= NOP;
      dec_pcA       <= '0;
      dec_pcB       <= '0;
      dec_validA    <= 1'b0;
      dec_validB    <= 1'b0;
      split_active  <= 1'b0;
    end else if (flush) begin
      state_reg    <= PAIR;
      dec_instA    <= NOP;
      dec_instB    <= NOP;
      dec_pcA      <= '0;
      dec_pcB      <= '0;
      dec_validA   <= 1'b0;
      dec_validB   <= 1'b0;
      split_active <= 1'b0;
    end else if (stage_free) begin
      if (show_hold) begin
        // Held B moves to slot A so it observes slot A's mapping.
        dec_instA    <= hold_inst_reg;
        dec_pcA      <= hold_pc_reg;
        dec_validA   <= 1'b1;
        dec_instB    <= NOP;
        dec_pcB      <= '0;
        dec_validB   <= 1'b0;
        split_active <= 1'b1;
      end else if (head_avail) begin
        dec_instA    <= head_inst_a;
        dec_pcA      <= head_pc_a;
        dec_validA   <= 1'b1;
        split_active <= 1'b0;
        if (head_hazard) begin
          dec_instB     <= NOP;
          dec_pcB       <= '0;
          dec_validB    <= 1'b0;
          hold_inst_reg <= head_inst_b;
          hold_pc_reg   <= head_pc_b;
          state_reg     <= SPLIT;
        end else begin
          dec_instB  <= head_inst_b;
          dec_pcB    <= head_pc_b;
          dec_validB <= 1'b1;
          state_reg  <= PAIR;
        end
      end else begin
        dec_instA    <= NOP;
        dec_instB    <= NOP;
        dec_pcA      <= '0;
        dec_pcB      <= '0;
        dec_validA   <= 1'b0;
        dec_validB   <= 1'b0;
        split_active <= 1'b0;
        state_reg    <= PAIR;
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic split_evt;
  logic stall_evt;
  assign split_evt = !flush && take_new && head_avail && head_hazard;
  assign stall_evt = out_valid && !dec_ready;

  // Saturating event counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (split_evt && (split_cnt != 32'hFFFFFFFF)) split_cnt <= split_cnt + 1'b1;
      if (stall_evt && (stall_cnt != 32'hFFFFFFFF)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Randomised bench for decode_issue_ctrl against a queue-based reference model.
module tb_decode_issue_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct {
    logic [31:0] ia;
    logic [31:0] ib;
    logic [31:0] pa;
    logic [31:0] pb;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_instA, fetch_instB, fetch_pcA, fetch_pcB;
  logic        fetch_ready;
  logic        dec_ready;
  logic        flush;
  logic [31:0] dec_instA, dec_instB, dec_pcA, dec_pcB;
  logic        dec_validA, dec_validB, split_active;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] split_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  decode_issue_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_valid  (fetch_valid),
    .fetch_instA  (fetch_instA),
    .fetch_instB  (fetch_instB),
    .fetch_pcA    (fetch_pcA),
    .fetch_pcB    (fetch_pcB),
    .fetch_ready  (fetch_ready),
    .dec_ready    (dec_ready),
    .flush        (flush),
    .dec_instA    (dec_instA),
    .dec_instB    (dec_instB),
    .dec_pcA      (dec_pcA),
    .dec_pcB      (dec_pcB),
    .dec_validA   (dec_validA),
    .dec_validB   (dec_validB),
    .split_active (split_active)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .split_cnt    (split_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Reference model state: buffered pairs, visible output beat, pending held B.
  pair_t       mq[$];
  logic        m_va, m_vb, m_split, m_pend;
  logic [31:0] m_ia, m_ib, m_pa, m_pb;
  pair_t       m_hold;
  int unsigned m_scnt, m_stcnt;

  function automatic bit ref_hazard(input logic [31:0] a, input logic [31:0] b);
    int rd, opa, opb, s1, s2;
    bit writes, reads2;
    rd     = int'((a >> 7) & 32'd31);
    opa    = int'(a & 32'd127);
    opb    = int'(b & 32'd127);
    s1     = int'((b >> 15) & 32'd31);
    s2     = int'((b >> 20) & 32'd31);
    writes = !(opa == 'h23 || opa == 'h63);
    reads2 = (opb == 'h33 || opb == 'h23 || opb == 'h63);
    return (rd != 0) && writes && (s1 == rd || (reads2 && s2 == rd));
  endfunction

  task automatic model_clear_out();
    m_va = 0; m_vb = 0; m_split = 0;
    m_ia = NOP; m_ib = NOP; m_pa = 0; m_pb = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    model_clear_out();
    m_pend = 0; m_scnt = 0; m_stcnt = 0;
  endtask

  task automatic model_step(input logic fv, input pair_t fp, input logic dr, input logic fl);
    bit    ov;
    pair_t h;
    ov = m_va || m_vb;
    if (ov && !dr && m_stcnt != 32'hFFFFFFFF) m_stcnt++;
    if (fl) begin
      mq.delete();
      model_clear_out();
      m_pend = 0;
      return;
    end
    if (fv && mq.size() < DEPTH) mq.push_back(fp);
    if (!ov || dr) begin
      if (m_pend) begin
        m_ia = m_hold.ib; m_pa = m_hold.pb; m_va = 1;
        m_ib = NOP; m_pb = 0; m_vb = 0; m_split = 1; m_pend = 0;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        m_ia = h.ia; m_pa = h.pa; m_va = 1; m_split = 0;
        if (ref_hazard(h.ia, h.ib)) begin
          m_ib = NOP; m_pb = 0; m_vb = 0; m_pend = 1; m_hold = h;
          if (m_scnt != 32'hFFFFFFFF) m_scnt++;
        end else begin
          m_ib = h.ib; m_pb = h.pb; m_vb = 1;
        end
      end else begin
        model_clear_out();
      end
    end
  endtask

  task automatic check_all(input int cyc);
    string s;
    s = $sformatf("c%0d", cyc);
    check_val({s, " validA"}, 64'(dec_validA), 64'(m_va));
    check_val({s, " validB"}, 64'(dec_validB), 64'(m_vb));
    check_val({s, " instA"}, 64'(dec_instA), 64'(m_ia));
    check_val({s, " instB"}, 64'(dec_instB), 64'(m_ib));
    check_val({s, " pcA"}, 64'(dec_pcA), 64'(m_pa));
    check_val({s, " pcB"}, 64'(dec_pcB), 64'(m_pb));
    check_val({s, " split_active"}, 64'(split_active), 64'(m_split));
    check_val({s, " fetch_ready"}, 64'(fetch_ready), 64'(mq.size() < DEPTH));
`ifdef ISSUE_PERF_CNT_EN
    check_val({s, " split_cnt"}, 64'(split_cnt), 64'(m_scnt));
    check_val({s, " stall_cnt"}, 64'(stall_cnt), 64'(m_stcnt));
`endif
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] op;
    logic [4:0] rd, r1, r2;
    case ($urandom_range(0, 4))
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0100011;
      3: op = 7'b1100011;
      default: op = 7'b0000011;
    endcase
    rd = 5'($urandom_range(0, 3));
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    return {7'b0, r2, r1, 3'b0, rd, op};
  endfunction

  // Directed opening pairs: independent, RAW, store exemption, x0 exemption, rs2 RAW.
  logic [31:0] dir_a [6] = '{32'h003100B3, 32'h003100B3, 32'h00112023, 32'h00000013, 32'h003100B3, 32'h003100B3};
  logic [31:0] dir_b [6] = '{32'h006282B3, 32'h00508233, 32'h00508233, 32'h00500233, 32'h00128233, 32'h006282B3};

  pair_t fp;
  bit    did_rst;
  bit    did_flush;

  initial begin
    rst_n = 0; fetch_valid = 0; dec_ready = 1; flush = 0;
    fetch_instA = 0; fetch_instB = 0; fetch_pcA = 0; fetch_pcB = 0;
    did_rst = 0; did_flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all(-1);
    rst_n = 1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      fp.pa = $urandom & 32'hFFFFFFFC;
      fp.pb = fp.pa + 4;
      if (cyc < 6) begin
        fp.ia = dir_a[cyc]; fp.ib = dir_b[cyc];
        fetch_valid = 1; dec_ready = 1; flush = 0;
      end else begin
        fp.ia = rand_inst(); fp.ib = rand_inst();
        if (cyc >= 40 && cyc < 60) begin
          fetch_valid = 1; dec_ready = 0; flush = 0;
        end else begin
          fetch_valid = ($urandom_range(0, 3) != 0);
          dec_ready   = ($urandom_range(0, 3) != 0);
          flush       = ($urandom_range(0, 29) == 0);
          if (!did_flush && cyc >= 200 && m_pend && mq.size() >= 2) begin
            flush = 1; fetch_valid = 1; did_flush = 1;
          end
        end
      end
      fetch_instA = fp.ia; fetch_instB = fp.ib; fetch_pcA = fp.pa; fetch_pcB = fp.pb;
      @(posedge clk);
      model_step(fetch_valid, fp, dec_ready, flush);
      #1;
      check_all(cyc);

      if (!did_rst && ((cyc >= 700 && (m_pend || m_split)) || cyc == 1000)) begin
        did_rst = 1;
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all(10000 + cyc);
        fetch_valid = 0; flush = 0; dec_ready = 1;
        @(posedge clk);
        #1 rst_n = 1;
        check_all(20000 + cyc);
      end
    end

    check_val("flush_in_split_seen", 64'(did_flush), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
